// File: rtl/ex_issue_buffer.sv
// Issue-to-execute staging buffer: per-lane 2-entry skid FIFO with
// ready/valid toward issue, FU stall, and ROB-id based selective squash.

package ex_issue_buffer_pkg;
   localparam int unsigned PRF_WIDTH = 7;
   localparam int unsigned ROB_WIDTH = 4;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       use_imm;
      logic       is_branch;
   } control_type;
endpackage

module ex_issue_buffer
   import ex_issue_buffer_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 3,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PRF_WIDTH = ex_issue_buffer_pkg::PRF_WIDTH,
   parameter int unsigned ROB_WIDTH = ex_issue_buffer_pkg::ROB_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               flush_valid,
   input  logic [ROB_WIDTH:0]                 flush_robid,
   input  logic [NUM_SLOTS-1:0]               in_valid,
   output logic [NUM_SLOTS-1:0]               in_ready,
   input  logic [NUM_SLOTS*XLEN-1:0]          in_pc,
   input  logic [NUM_SLOTS*XLEN-1:0]          in_rs1,
   input  logic [NUM_SLOTS*XLEN-1:0]          in_rs2,
   input  logic [NUM_SLOTS*PRF_WIDTH-1:0]     in_T,
   input  logic [NUM_SLOTS*(ROB_WIDTH+1)-1:0] in_robid,
   input  control_type                        in_control [NUM_SLOTS],
   input  logic [NUM_SLOTS-1:0]               fu_stall,
   output logic [NUM_SLOTS-1:0]               out_valid,
   output logic [NUM_SLOTS*XLEN-1:0]          out_pc,
   output logic [NUM_SLOTS*XLEN-1:0]          out_rs1,
   output logic [NUM_SLOTS*XLEN-1:0]          out_rs2,
   output logic [NUM_SLOTS*PRF_WIDTH-1:0]     out_T,
   output logic [NUM_SLOTS*(ROB_WIDTH+1)-1:0] out_robid,
   output control_type                        out_control [NUM_SLOTS],
   output logic [NUM_SLOTS*2-1:0]             occupancy
);

   localparam int unsigned RW  = ROB_WIDTH + 1;
   localparam int unsigned CW  = $bits(control_type);
   localparam int unsigned TO  = CW + RW;
   localparam int unsigned S2O = TO + PRF_WIDTH;
   localparam int unsigned S1O = S2O + XLEN;
   localparam int unsigned PCO = S1O + XLEN;
   localparam int unsigned PW  = PCO + XLEN;

   // Younger-than-flush test; equal ids are the flusher itself and survive.
   function automatic logic young(input logic [RW-1:0] r, input logic [RW-1:0] f);
      return r[ROB_WIDTH] ^ f[ROB_WIDTH] ^ (r[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]);
   endfunction

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
      logic          v0_q, v1_q, v0_d, v1_d;
      logic [PW-1:0] e0_q, e1_q, e0_d, e1_d;
      logic [PW-1:0] in_pay;
      logic          enq, deq, keep0, keep1;

      assign in_pay = {in_pc[i*XLEN +: XLEN], in_rs1[i*XLEN +: XLEN],
                       in_rs2[i*XLEN +: XLEN], in_T[i*PRF_WIDTH +: PRF_WIDTH],
                       in_robid[i*RW +: RW], in_control[i]};

      assign in_ready[i] = ~(v0_q & v1_q);
      assign enq   = in_valid[i] & ~(v0_q & v1_q) & ~flush_valid;
      assign deq   = v0_q & ~flush_valid & ~fu_stall[i];
      assign keep0 = v0_q & ~young(e0_q[CW +: RW], flush_robid);
      assign keep1 = v1_q & ~young(e1_q[CW +: RW], flush_robid);

      // Next state: squash+compact on flush, else shift on dequeue then fill first free slot.
      always_comb begin
         v0_d = v0_q;
         v1_d = v1_q;
         e0_d = e0_q;
         e1_d = e1_q;
         if (flush_valid) begin
            if (!keep0 && keep1) begin
               v0_d = 1'b1;
               e0_d = e1_q;
               v1_d = 1'b0;
            end else begin
               v0_d = keep0;
               v1_d = keep1;
            end
         end else begin
            if (deq) begin
               v0_d = v1_q;
               e0_d = e1_q;
               v1_d = 1'b0;
            end
            if (enq) begin
               if (!v0_d) begin
                  v0_d = 1'b1;
                  e0_d = in_pay;
               end else begin
                  v1_d = 1'b1;
                  e1_d = in_pay;
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
         end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
         end
      end

      // Payload is not reset; only the valid bits qualify it.
      always_ff @(posedge clk) begin
         e0_q <= e0_d;
         e1_q <= e1_d;
      end

      assign out_valid[i]                   = v0_q & ~flush_valid;
      assign out_pc[i*XLEN +: XLEN]         = e0_q[PCO +: XLEN];
      assign out_rs1[i*XLEN +: XLEN]        = e0_q[S1O +: XLEN];
      assign out_rs2[i*XLEN +: XLEN]        = e0_q[S2O +: XLEN];
      assign out_T[i*PRF_WIDTH +: PRF_WIDTH] = e0_q[TO +: PRF_WIDTH];
      assign out_robid[i*RW +: RW]          = e0_q[CW +: RW];
      assign out_control[i]                 = control_type'(e0_q[CW-1:0]);
      assign occupancy[i*2 +: 2]            = 2'(v0_q) + 2'(v1_q);
   end

endmodule

// File: tb/tb_ex_issue_buffer.sv
// Bench for ex_issue_buffer: queue-based per-lane model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_ex_issue_buffer;
   import ex_issue_buffer_pkg::*;

   localparam int NS = 3;
   localparam int XL = 32;
   localparam int TW = 7;
   localparam int RW = 5;

   typedef struct packed {
      logic [XL-1:0] pc;
      logic [XL-1:0] rs1;
      logic [XL-1:0] rs2;
      logic [TW-1:0] t;
      logic [RW-1:0] rob;
      control_type   ctl;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             flush_valid = 1'b0;
   logic [RW-1:0]    flush_robid = '0;
   logic [NS-1:0]    in_valid = '0;
   logic [NS-1:0]    in_ready;
   logic [NS*XL-1:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0;
   logic [NS*TW-1:0] in_T = '0;
   logic [NS*RW-1:0] in_robid = '0;
   control_type      in_control [NS];
   logic [NS-1:0]    fu_stall = '0;
   logic [NS-1:0]    out_valid;
   logic [NS*XL-1:0] out_pc, out_rs1, out_rs2;
   logic [NS*TW-1:0] out_T;
   logic [NS*RW-1:0] out_robid;
   control_type      out_control [NS];
   logic [NS*2-1:0]  occupancy;

   ex_issue_buffer #(.NUM_SLOTS(NS), .XLEN(XL), .PRF_WIDTH(TW), .ROB_WIDTH(RW-1)) dut (
      .clk(clk), .reset_n(reset_n), .flush_valid(flush_valid), .flush_robid(flush_robid),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_T(in_T), .in_robid(in_robid), .in_control(in_control),
      .fu_stall(fu_stall), .out_valid(out_valid), .out_pc(out_pc), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_T(out_T), .out_robid(out_robid), .out_control(out_control),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass = 0;
   bit   cmp_en = 1'b0;
   ent_t mq [NS][$];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Younger = later in program order relative to the flusher, accounting for wrap.
   function automatic bit m_young(input logic [RW-1:0] r, input logic [RW-1:0] f);
      if (r[RW-1] == f[RW-1]) return r[RW-2:0] > f[RW-2:0];
      return r[RW-2:0] <= f[RW-2:0];
   endfunction

   function automatic ent_t cur_in(input int l);
      ent_t e;
      e.pc  = in_pc[l*XL +: XL];
      e.rs1 = in_rs1[l*XL +: XL];
      e.rs2 = in_rs2[l*XL +: XL];
      e.t   = in_T[l*TW +: TW];
      e.rob = in_robid[l*RW +: RW];
      e.ctl = in_control[l];
      return e;
   endfunction

   function automatic ent_t dut_head(input int l);
      ent_t e;
      e.pc  = out_pc[l*XL +: XL];
      e.rs1 = out_rs1[l*XL +: XL];
      e.rs2 = out_rs2[l*XL +: XL];
      e.t   = out_T[l*TW +: TW];
      e.rob = out_robid[l*RW +: RW];
      e.ctl = out_control[l];
      return e;
   endfunction

   task automatic model_step();
      for (int l = 0; l < NS; l++) begin
         if (!reset_n) begin
            mq[l].delete();
         end else if (flush_valid) begin
            ent_t kept[$];
            kept = {};
            foreach (mq[l][k]) if (!m_young(mq[l][k].rob, flush_robid)) kept.push_back(mq[l][k]);
            mq[l] = kept;
         end else begin
            bit take;
            take = in_valid[l] && (mq[l].size() < 2);
            if (mq[l].size() > 0 && !fu_stall[l]) void'(mq[l].pop_front());
            if (take) mq[l].push_back(cur_in(l));
         end
      end
   endtask

   // One clock: the edge consumes current inputs, then inputs may change.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input int l, input logic [XL-1:0] pc, input logic [XL-1:0] rs1,
                        input logic [XL-1:0] rs2, input logic [RW-1:0] rob);
      in_valid[l]          = 1'b1;
      in_pc[l*XL +: XL]    = pc;
      in_rs1[l*XL +: XL]   = rs1;
      in_rs2[l*XL +: XL]   = rs2;
      in_T[l*TW +: TW]     = TW'($urandom);
      in_robid[l*RW +: RW] = rob;
      in_control[l]        = control_type'($urandom_range(0, 63));
   endtask

   task automatic idle();
      in_valid    = '0;
      fu_stall    = '0;
      flush_valid = 1'b0;
   endtask

   // Model comparison on every falling edge once reset has been applied.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         for (int l = 0; l < NS; l++) begin
            bit exp_v;
            exp_v = (mq[l].size() > 0) && !flush_valid;
            chk($sformatf("occupancy[%0d]", l), 160'(occupancy[l*2 +: 2]), 160'(mq[l].size()));
            chk($sformatf("in_ready[%0d]", l), 160'(in_ready[l]), 160'(mq[l].size() < 2));
            chk($sformatf("out_valid[%0d]", l), 160'(out_valid[l]), 160'(exp_v));
            if (exp_v) chk($sformatf("head[%0d]", l), 160'(dut_head(l)), 160'(mq[l][0]));
         end
      end
   end

   initial begin
      logic [RW-1:0] got[$];
      for (int l = 0; l < NS; l++) in_control[l] = '0;
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      cmp_en  = 1'b1;
      chk("reset occupancy", 160'(occupancy), 160'(0));
      chk("reset in_ready", 160'(in_ready), 160'(3'b111));
      chk("reset out_valid", 160'(out_valid), 160'(0));

      // Single issue on lane 0, no stall.
      drive(0, 32'h100, 32'd5, 32'd7, 5'd3);
      cyc();
      in_valid = '0;
      chk("t1 out_valid0", 160'(out_valid[0]), 160'(1));
      chk("t1 out_pc0", 160'(out_pc[31:0]), 160'(32'h100));
      chk("t1 out_rs1_0", 160'(out_rs1[31:0]), 160'(5));
      chk("t1 out_rs2_0", 160'(out_rs2[31:0]), 160'(7));
      chk("t1 out_robid0", 160'(out_robid[4:0]), 160'(3));
      chk("t1 occ0 one", 160'(occupancy[1:0]), 160'(1));
      cyc();
      chk("t1 occ0 zero", 160'(occupancy[1:0]), 160'(0));

      // Lane 2 stalled: third issue must wait, then all drain in order.
      fu_stall[2] = 1'b1;
      drive(2, 32'h200, 32'd1, 32'd1, 5'd4);
      cyc();
      drive(2, 32'h204, 32'd2, 32'd2, 5'd5);
      cyc();
      drive(2, 32'h208, 32'd3, 32'd3, 5'd6);
      chk("t2 in_ready2 low", 160'(in_ready[2]), 160'(0));
      cyc();
      fu_stall[2] = 1'b0;
      for (int n = 0; n < 8; n++) begin
         bit acc;
         acc = in_valid[2] && in_ready[2];
         if (out_valid[2] && !fu_stall[2]) got.push_back(out_robid[14:10]);
         cyc();
         if (acc) in_valid[2] = 1'b0;
      end
      chk("t2 drained count", 160'(got.size()), 160'(3));
      if (got.size() == 3) begin
         chk("t2 order0", 160'(got[0]), 160'(4));
         chk("t2 order1", 160'(got[1]), 160'(5));
         chk("t2 order2", 160'(got[2]), 160'(6));
      end

      // Lane 1 selective squash of the younger skid entry.
      idle();
      fu_stall[1] = 1'b1;
      drive(1, 32'h300, 32'd0, 32'd0, 5'd2);
      cyc();
      drive(1, 32'h304, 32'd0, 32'd0, 5'd9);
      cyc();
      in_valid    = '0;
      flush_valid = 1'b1;
      flush_robid = 5'd5;
      #1;
      chk("t3 flush out_valid1", 160'(out_valid[1]), 160'(0));
      cyc();
      flush_valid = 1'b0;
      #1;
      chk("t3 survivor valid", 160'(out_valid[1]), 160'(1));
      chk("t3 survivor robid", 160'(out_robid[9:5]), 160'(2));
      chk("t3 survivor occ", 160'(occupancy[3:2]), 160'(1));

      // Wrap: head is younger across the wrap, skid survives and compacts.
      fu_stall[1] = 1'b0;
      cyc();
      fu_stall[1] = 1'b1;
      drive(1, 32'h400, 32'd0, 32'd0, 5'b10011);
      cyc();
      drive(1, 32'h404, 32'd0, 32'd0, 5'b01110);
      cyc();
      in_valid    = '0;
      flush_valid = 1'b1;
      flush_robid = 5'b01111;
      cyc();
      flush_valid = 1'b0;
      #1;
      chk("t4 wrap robid", 160'(out_robid[9:5]), 160'(5'b01110));
      chk("t4 wrap pc", 160'(out_pc[63:32]), 160'(32'h404));
      chk("t4 wrap occ", 160'(occupancy[3:2]), 160'(1));

      // Issue on every lane during a flush is dropped.
      for (int l = 0; l < NS; l++) drive(l, 32'h500, 32'd0, 32'd0, 5'd1);
      flush_valid = 1'b1;
      flush_robid = 5'b01111;
      cyc();
      idle();
      chk("t5 flush drops issue", 160'(occupancy), 160'(6'b00_01_00));

      // Reset while full and stalled.
      cyc();
      fu_stall = 3'b111;
      for (int n = 0; n < 2; n++) begin
         for (int l = 0; l < NS; l++) drive(l, 32'h600 + 32'(n), 32'd0, 32'd0, 5'(n + 1));
         cyc();
      end
      in_valid = '0;
      chk("t6 full occ", 160'(occupancy), 160'(6'b10_10_10));
      reset_n = 1'b0;
      flush_valid = 1'b1;
      cyc();
      reset_n = 1'b1;
      flush_valid = 1'b0;
      chk("t6 reset out_valid", 160'(out_valid), 160'(0));
      chk("t6 reset occ", 160'(occupancy), 160'(0));
      chk("t6 reset in_ready", 160'(in_ready), 160'(3'b111));
      fu_stall = '0;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset_n     = ($urandom_range(0, 399) != 0);
         flush_valid = ($urandom_range(0, 7) == 0);
         flush_robid = RW'($urandom);
         fu_stall    = '0;
         for (int l = 0; l < NS; l++) begin
            fu_stall[l] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
               drive(l, $urandom, $urandom, $urandom, RW'($urandom));
            else
               in_valid[l] = 1'b0;
         end
         cyc();
      end
      idle();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
